// File: rtl/fetch_if.sv
// Fetch sequencer bus: pipeline controls, instruction-memory port and EX-stage outputs.
// The sequencer uses the master view; the core and instruction RAM use the slave view.
interface fetch_if #(
    parameter int PC_W   = 12,
    parameter int INST_W = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt_req;
    logic              resume;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst_ex;
    logic [PC_W-1:0]   pc_ex;
    logic              inst_valid_ex;
    logic              halted;
    logic [31:0]       issue_count;

    modport master (
        input  stall, redirect_valid, redirect_pc, halt_req, resume, imem_rdata,
        output imem_addr, inst_ex, pc_ex, inst_valid_ex, halted, issue_count
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, halt_req, resume, imem_rdata,
        input  imem_addr, inst_ex, pc_ex, inst_valid_ex, halted, issue_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC and FETCH->EX issue controller: sequential fetch with stall,
// redirect flush, halt/resume and a count of instructions retired from EX.
module fetch_sequencer #(
    parameter int                PC_W     = 12,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_fetch_q, pc_fetch_d;
    logic [PC_W-1:0]   pc_ex_q, pc_ex_d;
    logic [INST_W-1:0] inst_ex_q, inst_ex_d;
    logic              inst_valid_ex_q, inst_valid_ex_d;
    logic              halted_q, halted_d;
    logic [31:0]       issue_count_q, issue_count_d;

    always_comb begin
        state_d         = state_q;
        pc_fetch_d      = pc_fetch_q;
        pc_ex_d         = pc_ex_q;
        inst_ex_d       = inst_ex_q;
        inst_valid_ex_d = inst_valid_ex_q;
        issue_count_d   = issue_count_q;

        if (state_q == ST_RUN) begin
            // A redirect or halt also retires the EX instruction, even under stall for redirect.
            if (inst_valid_ex_q && (bus.redirect_valid || !bus.stall)) begin
                issue_count_d = issue_count_q + 32'd1;
            end

            if (bus.redirect_valid) begin
                pc_fetch_d      = bus.redirect_pc;
                inst_ex_d       = NOP_INST;
                inst_valid_ex_d = 1'b0;
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                end
            end else if (!bus.stall) begin
                if (bus.halt_req) begin
                    // The word at pc_fetch is left unconsumed and refetched after resume.
                    state_d         = ST_HALT;
                    inst_ex_d       = NOP_INST;
                    inst_valid_ex_d = 1'b0;
                end else begin
                    inst_ex_d       = bus.imem_rdata;
                    pc_ex_d         = pc_fetch_q;
                    inst_valid_ex_d = 1'b1;
                    pc_fetch_d      = pc_fetch_q + 1'b1;
                end
            end
        end else begin
            inst_ex_d       = NOP_INST;
            inst_valid_ex_d = 1'b0;
            if (bus.redirect_valid) begin
                pc_fetch_d = bus.redirect_pc;
            end
            if (bus.resume && !bus.halt_req) begin
                state_d = ST_RUN;
            end
        end

        halted_d = (state_d == ST_HALT);
    end

    // FETCH -> EX stage boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            pc_fetch_q      <= '0;
            pc_ex_q         <= '0;
            inst_ex_q       <= NOP_INST;
            inst_valid_ex_q <= 1'b0;
            halted_q        <= 1'b0;
            issue_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            pc_fetch_q      <= pc_fetch_d;
            pc_ex_q         <= pc_ex_d;
            inst_ex_q       <= inst_ex_d;
            inst_valid_ex_q <= inst_valid_ex_d;
            halted_q        <= halted_d;
            issue_count_q   <= issue_count_d;
        end
    end

    assign bus.imem_addr     = pc_fetch_q;
    assign bus.inst_ex       = inst_ex_q;
    assign bus.pc_ex         = pc_ex_q;
    assign bus.inst_valid_ex = inst_valid_ex_q;
    assign bus.halted        = halted_q;
    assign bus.issue_count   = issue_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch/issue rules.
module tb_fetch_sequencer;

    localparam int          PC_W  = 12;
    localparam int          INST_W = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [INST_W-1:0] imem [0:(1<<PC_W)-1];

    fetch_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

    fetch_sequencer #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = imem[bus.imem_addr];

    always #5 clk = ~clk;

    // Reference model state, advanced once per clock edge from the same inputs.
    logic [PC_W-1:0] m_pc, m_pcex;
    logic [31:0]     m_inst, m_cnt;
    bit              m_valid, m_halt;

    task automatic model_edge();
        bit retire;
        if (!rst_n) begin
            m_pc = '0; m_pcex = '0; m_inst = NOP; m_valid = 0; m_halt = 0; m_cnt = '0;
        end else if (m_halt) begin
            if (bus.redirect_valid) m_pc = bus.redirect_pc;
            if (bus.resume && !bus.halt_req) m_halt = 0;
        end else begin
            retire = m_valid && (bus.redirect_valid || !bus.stall);
            if (bus.redirect_valid) begin
                m_pc = bus.redirect_pc; m_inst = NOP; m_valid = 0; m_halt = bus.halt_req;
            end else if (!bus.stall) begin
                if (bus.halt_req) begin
                    m_halt = 1; m_inst = NOP; m_valid = 0;
                end else begin
                    m_inst = imem[m_pc]; m_pcex = m_pc; m_valid = 1; m_pc = m_pc + 1'b1;
                end
            end
            if (retire) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit st, input bit rv, input logic [PC_W-1:0] rpc,
                         input bit hr, input bit rs);
        bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
        bus.halt_req = hr; bus.resume = rs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 12'h0AB, 1, 0);
        tick();
        checks += 6;
        if (bus.imem_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", bus.imem_addr); end
        if (bus.inst_ex !== NOP) begin errors++; $display("FAIL reset_inst got %0h want %0h", bus.inst_ex, NOP); end
        if (bus.pc_ex !== 12'd0) begin errors++; $display("FAIL reset_pc_ex got %0h want 0", bus.pc_ex); end
        if (bus.inst_valid_ex !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.inst_valid_ex); end
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        if (bus.issue_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.issue_count); end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        drive(0, 0, '0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) begin
                checks += 3;
                if (bus.inst_ex !== 32'h100 + k) begin errors++; $display("FAIL seq_inst%0d got %0h want %0h", k, bus.inst_ex, 32'h100 + k); end
                if (bus.pc_ex !== PC_W'(k)) begin errors++; $display("FAIL seq_pc%0d got %0d want %0d", k, bus.pc_ex, k); end
                if (bus.inst_valid_ex !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b want 1", k, bus.inst_valid_ex); end
            end
        end
        checks++;
        if (bus.issue_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d want 3", bus.issue_count); end
    endtask

    task automatic test_stall();
        tick(); tick();
        checks++;
        if (bus.pc_ex !== 12'd5) begin errors++; $display("FAIL stall_setup_pc got %0d want 5", bus.pc_ex); end
        drive(1, 0, '0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 4;
            if (bus.pc_ex !== 12'd5) begin errors++; $display("FAIL stall_pc%0d got %0d want 5", k, bus.pc_ex); end
            if (bus.inst_ex !== 32'h105) begin errors++; $display("FAIL stall_inst%0d got %0h want 105", k, bus.inst_ex); end
            if (bus.imem_addr !== 12'd6) begin errors++; $display("FAIL stall_addr%0d got %0d want 6", k, bus.imem_addr); end
            if (bus.issue_count !== 32'd5) begin errors++; $display("FAIL stall_count%0d got %0d want 5", k, bus.issue_count); end
        end
        drive(0, 0, '0, 0, 0);
        tick();
        checks += 2;
        if (bus.pc_ex !== 12'd6) begin errors++; $display("FAIL stall_release_pc got %0d want 6", bus.pc_ex); end
        if (bus.issue_count !== 32'd6) begin errors++; $display("FAIL stall_release_count got %0d want 6", bus.issue_count); end
    endtask

    task automatic test_redirect();
        drive(1, 1, 12'h200, 0, 0);
        tick();
        checks += 4;
        if (bus.inst_valid_ex !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", bus.inst_valid_ex); end
        if (bus.inst_ex !== NOP) begin errors++; $display("FAIL redir_inst got %0h want %0h", bus.inst_ex, NOP); end
        if (bus.imem_addr !== 12'h200) begin errors++; $display("FAIL redir_addr got %0h want 200", bus.imem_addr); end
        if (bus.issue_count !== 32'd7) begin errors++; $display("FAIL redir_count got %0d want 7", bus.issue_count); end
        drive(0, 0, '0, 0, 0);
        tick();
        checks += 3;
        if (bus.pc_ex !== 12'h200) begin errors++; $display("FAIL redir_target_pc got %0h want 200", bus.pc_ex); end
        if (bus.inst_valid_ex !== 1'b1) begin errors++; $display("FAIL redir_target_valid got %b want 1", bus.inst_valid_ex); end
        if (bus.inst_ex !== 32'h300) begin errors++; $display("FAIL redir_target_inst got %0h want 300", bus.inst_ex); end
    endtask

    task automatic test_halt();
        drive(0, 1, 12'd9, 0, 0);
        tick();
        drive(0, 0, '0, 1, 0);
        tick();
        drive(0, 0, '0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_flag%0d got %b want 1", k, bus.halted); end
            if (bus.inst_valid_ex !== 1'b0 || bus.inst_ex !== NOP) begin errors++; $display("FAIL halt_bubble%0d got %b/%0h want 0/%0h", k, bus.inst_valid_ex, bus.inst_ex, NOP); end
            if (bus.imem_addr !== 12'd9) begin errors++; $display("FAIL halt_addr%0d got %0d want 9", k, bus.imem_addr); end
            bus.stall = 1'($urandom);
            tick();
        end
        drive(0, 0, '0, 0, 1);
        tick();
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_flag got %b want 0", bus.halted); end
        if (bus.inst_valid_ex !== 1'b0) begin errors++; $display("FAIL resume_valid got %b want 0", bus.inst_valid_ex); end
        drive(0, 0, '0, 0, 0);
        tick();
        checks += 2;
        if (bus.pc_ex !== 12'd9 || bus.inst_valid_ex !== 1'b1) begin errors++; $display("FAIL resume_fetch got pc %0d v %b want 9 v 1", bus.pc_ex, bus.inst_valid_ex); end
        if (bus.inst_ex !== 32'h109) begin errors++; $display("FAIL resume_inst got %0h want 109", bus.inst_ex); end
    endtask

    task automatic test_halt_corners();
        drive(1, 0, '0, 1, 0);
        tick();
        checks += 2;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_under_stall got %b want 0", bus.halted); end
        if (bus.inst_ex !== 32'h109 || bus.inst_valid_ex !== 1'b1) begin errors++; $display("FAIL halt_under_stall_hold got %0h/%b want 109/1", bus.inst_ex, bus.inst_valid_ex); end
        drive(0, 0, '0, 1, 0);
        tick();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL halt_after_stall got %b want 1", bus.halted); end
        drive(0, 0, '0, 1, 1);
        tick();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL resume_with_halt got %b want 1", bus.halted); end
        drive(0, 0, '0, 0, 1);
        tick();
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL resume_alone got %b want 0", bus.halted); end
    endtask

    task automatic test_wrap();
        drive(0, 1, 12'd4095, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0);
        tick();
        checks += 3;
        if (bus.imem_addr !== 12'd0) begin errors++; $display("FAIL wrap_addr got %0d want 0", bus.imem_addr); end
        if (bus.pc_ex !== 12'd4095 || bus.inst_valid_ex !== 1'b1) begin errors++; $display("FAIL wrap_pc got %0d v %b want 4095 v 1", bus.pc_ex, bus.inst_valid_ex); end
        if (bus.inst_ex !== 32'h10FF) begin errors++; $display("FAIL wrap_inst got %0h want 10ff", bus.inst_ex); end
    endtask

    task automatic test_reset_in_halt();
        drive(0, 0, '0, 1, 0);
        tick();
        checks++;
        if (bus.halted !== 1'b1) begin errors++; $display("FAIL rst_halt_setup got %b want 1", bus.halted); end
        rst_n = 1'b0;
        drive(1, 1, 12'h055, 1, 0);
        tick();
        checks += 4;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halt_flag got %b want 0", bus.halted); end
        if (bus.imem_addr !== 12'd0) begin errors++; $display("FAIL rst_halt_addr got %0h want 0", bus.imem_addr); end
        if (bus.inst_ex !== NOP || bus.inst_valid_ex !== 1'b0 || bus.pc_ex !== 12'd0) begin errors++; $display("FAIL rst_halt_ex got %0h/%b/%0h want %0h/0/0", bus.inst_ex, bus.inst_valid_ex, bus.pc_ex, NOP); end
        if (bus.issue_count !== 32'd0) begin errors++; $display("FAIL rst_halt_count got %0d want 0", bus.issue_count); end
        rst_n = 1'b1;
        drive(0, 0, '0, 0, 0);
        tick();
        checks++;
        if (bus.pc_ex !== 12'd0 || bus.inst_valid_ex !== 1'b1 || bus.imem_addr !== 12'd1) begin errors++; $display("FAIL rst_halt_run got pc %0d v %b addr %0d want 0 1 1", bus.pc_ex, bus.inst_valid_ex, bus.imem_addr); end
    endtask

    task automatic test_random();
        for (int k = 0; k < (1 << PC_W); k++) imem[k] = $urandom;
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, PC_W'($urandom),
                  $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0);
            tick();
            checks += 6;
            if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr@%0d got %0h want %0h", n, bus.imem_addr, m_pc); end
            if (bus.inst_ex !== m_inst) begin errors++; $display("FAIL rnd_inst@%0d got %0h want %0h", n, bus.inst_ex, m_inst); end
            if (bus.pc_ex !== m_pcex) begin errors++; $display("FAIL rnd_pc_ex@%0d got %0h want %0h", n, bus.pc_ex, m_pcex); end
            if (bus.inst_valid_ex !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d got %b want %b", n, bus.inst_valid_ex, m_valid); end
            if (bus.halted !== m_halt) begin errors++; $display("FAIL rnd_halted@%0d got %b want %b", n, bus.halted, m_halt); end
            if (bus.issue_count !== m_cnt) begin errors++; $display("FAIL rnd_count@%0d got %0d want %0d", n, bus.issue_count, m_cnt); end
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << PC_W); k++) imem[k] = 32'h100 + k;
        drive(0, 0, '0, 0, 0);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_corners();
        test_wrap();
        test_reset_in_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
